// File: rtl/gate_exerciser.sv
// gate_exerciser: sweeps A/B over a two-input gate unit and checks its AND/OR/NOT-A outputs.
module gate_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  output logic             o_drv_a,
  output logic             o_drv_b,
  input  logic             i_dut_and,
  input  logic             i_dut_or,
  input  logic             i_dut_not,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [1:0]       o_first_fail_vec,
  output logic             o_first_fail_valid
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0]       r_vec;
  logic [SW-1:0]    r_settle;
  logic [PW-1:0]    r_pass_cnt;
  logic [ERR_W-1:0] r_err;
  logic             r_pass;
  logic [1:0]       r_ff_vec;
  logic             r_ff_valid;
  logic             w_fail;
  assign w_fail = (i_dut_and != (r_vec[1] & r_vec[0])) |
                  (i_dut_or  != (r_vec[1] | r_vec[0])) |
                  (i_dut_not != ~r_vec[1]);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? SETTLE : IDLE;
      SETTLE:  w_next = (r_settle == SETTLE_LAST) ? CHECK : SETTLE;
      CHECK:   w_next = (r_vec == 2'd3 && r_pass_cnt == PASS_LAST) ? DONE : SETTLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    o_busy = r_state != IDLE;
    o_done = r_state == DONE;
  end
  // vec only advances when another SETTLE follows, so the drive lines park on 11 after a run
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_vec      <= '0;
      r_settle   <= '0;
      r_pass_cnt <= '0;
      r_err      <= '0;
      r_pass     <= 1'b0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_vec      <= '0;
        r_settle   <= '0;
        r_pass_cnt <= '0;
        r_err      <= '0;
        r_pass     <= 1'b0;
        r_ff_vec   <= '0;
        r_ff_valid <= 1'b0;
      end
      if (r_state == SETTLE) r_settle <= r_settle + 1'b1;
      if (r_state == CHECK) begin
        r_settle <= '0;
        if (w_fail) begin
          if (r_err != '1) r_err <= r_err + 1'b1;
          if (!r_ff_valid) begin
            r_ff_vec   <= r_vec;
            r_ff_valid <= 1'b1;
          end
        end
        if (w_next == SETTLE) begin
          r_vec <= r_vec + 1'b1;
          if (r_vec == 2'd3) r_pass_cnt <= r_pass_cnt + 1'b1;
        end
      end
      if (r_state == DONE) r_pass <= (r_err == '0);
    end
  assign o_drv_a            = r_vec[1];
  assign o_drv_b            = r_vec[0];
  assign o_pass             = r_pass;
  assign o_err_count        = r_err;
  assign o_first_fail_vec   = r_ff_vec;
  assign o_first_fail_valid = r_ff_valid;
endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: directed runs of three exerciser configurations against a faultable gate model.
module tb_gate_exerciser;
  logic clk = 1'b0;
  logic reset_n, start;
  logic [1:0] fm;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;

  function automatic logic [2:0] gate(input logic a, input logic b, input logic [1:0] m);
    logic [2:0] g;
    g = {a & b, a | b, ~a};
    case (m)
      2'd1:    g[2] = 1'b0;
      2'd2:    g[0] = a;
      2'd3:    g = ~g;
      default: ;
    endcase
    return g;
  endfunction

  logic a0, b0, and0, or0, not0, busy0, done0, pass0, ffv0;
  logic a1, b1, and1, or1, not1, busy1, done1, pass1, ffv1;
  logic a2, b2, and2, or2, not2, busy2, done2, pass2, ffv2;
  logic [7:0] err0, err1;
  logic [1:0] err2, ff0, ff1, ff2;
  assign {and0, or0, not0} = gate(a0, b0, fm);
  assign {and1, or1, not1} = gate(a1, b1, fm);
  assign {and2, or2, not2} = gate(a2, b2, fm);

  gate_exerciser #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(8)) u0 (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .o_drv_a(a0), .o_drv_b(b0),
    .i_dut_and(and0), .i_dut_or(or0), .i_dut_not(not0), .o_busy(busy0), .o_done(done0),
    .o_pass(pass0), .o_err_count(err0), .o_first_fail_vec(ff0), .o_first_fail_valid(ffv0));
  gate_exerciser #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(8)) u1 (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .o_drv_a(a1), .o_drv_b(b1),
    .i_dut_and(and1), .i_dut_or(or1), .i_dut_not(not1), .o_busy(busy1), .o_done(done1),
    .o_pass(pass1), .o_err_count(err1), .o_first_fail_vec(ff1), .o_first_fail_valid(ffv1));
  gate_exerciser #(.SETTLE_CYCLES(2), .PASSES(2), .ERR_W(2)) u2 (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .o_drv_a(a2), .o_drv_b(b2),
    .i_dut_and(and2), .i_dut_or(or2), .i_dut_not(not2), .o_busy(busy2), .o_done(done2),
    .o_pass(pass2), .o_err_count(err2), .o_first_fail_vec(ff2), .o_first_fail_valid(ffv2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [1:0] dlog [40];
  logic       blog [40];
  int n0, d0, d0l, d1;

  // offset i is the cycle after the i-th edge following the start-sampling edge; done cycle = i+1
  task automatic run(input int pulse_at, input bit hold, input int rst_at);
    n0 = 0; d0 = 0; d0l = 0; d1 = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = hold || (i == pulse_at);
      dlog[i] = {a0, b0};
      blog[i] = busy0;
      if (done0) begin
        n0++;
        if (d0 == 0) d0 = i + 1;
        d0l = i + 1;
      end
      if (done1 && d1 == 0) d1 = i + 1;
      if (i == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_mid_drv", {a0, b0}, 0);
        check("rst_mid_busy", busy0, 0);
        check("rst_mid_err", err0, 0);
        check("rst_mid_ffv", ffv0, 0);
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; fm = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_drv", {a0, b0}, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err", err0, 0);
    check("rst_ffv", {ffv0, ff0}, 0);
    reset_n = 1'b1;

    run(-1, 0, -1);
    check("t1_done_cyc", d0, 13);
    check("t1_done_pulses", n0, 1);
    check("t1_p2_done_cyc", d1, 25);
    for (int k = 0; k < 12; k++) check("t1_drv_seq", dlog[k], k / 3);
    check("t1_drv_hold", dlog[13], 3);
    check("t1_pass", pass0, 1);
    check("t1_err", err0, 0);
    check("t1_ffv", ffv0, 0);
    check("t1_p2_pass", pass1, 1);
    check("t1_w2_pass", pass2, 1);

    fm = 2'd1;
    run(-1, 0, -1);
    check("t2_err", err0, 1);
    check("t2_ffvec", ff0, 3);
    check("t2_ffv", ffv0, 1);
    check("t2_pass", pass0, 0);
    check("t2_p2_err", err1, 2);

    fm = 2'd2;
    run(-1, 0, -1);
    check("t3_err", err0, 4);
    check("t3_ffvec", ff0, 0);
    check("t3_p2_err", err1, 8);
    check("t3_p2_done_cyc", d1, 25);

    fm = 2'd3;
    run(-1, 0, -1);
    check("t6_sat_err", err2, 3);
    check("t6_ffvec", ff2, 0);
    check("t6_ffv", ffv2, 1);
    check("t6_pass", pass2, 0);
    check("t6_p2_err", err1, 8);

    fm = 2'd0;
    run(4, 0, -1);
    check("t4_pulse_done_cyc", d0, 13);
    check("t4_pulse_pulses", n0, 1);
    check("t4_pulse_pass", pass0, 1);

    run(-1, 1, -1);
    check("t4_hold_done_cyc", d0, 13);
    check("t4_hold_idle", blog[13], 0);
    check("t4_hold_restart", blog[14], 1);
    check("t4_hold_restart_drv", dlog[14], 0);
    check("t4_hold_second_done", d0l, 27);

    fm = 2'd3;
    run(-1, 0, 7);
    check("t5_no_done", n0, 0);
    fm = 2'd0;
    run(-1, 0, -1);
    check("t5_clean_done_cyc", d0, 13);
    check("t5_clean_pass", pass0, 1);
    check("t5_clean_err", err0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
